decoder2to4_stream: RTL
=======================

Name: decoder2to4_stream

Overview:
- Registered 2-to-4 decoder with valid/ready handshakes on both sides; the companion of the codebase's 4-to-2 encoder, turning a 2-bit code back into a one-hot bus.
- A 2-entry output buffer decouples upstream from downstream backpressure.
- Per-line saturating hit counters support coverage and debug.
- Sits between any 2-bit code producer and a one-hot consumer.

Parameters:
- CNT_W, 8, width of each per-line hit counter (valid range 1..16).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents in_code.
- in_ready  output  1  block can accept a code this cycle.
- in_code  input  2  code to decode, 0..3.
- en  input  1  sampled with each accepted code; 0 makes that entry decode to 4'b0000.
- out_valid  output  1  out holds a valid decoded entry.
- out_ready  input  1  downstream accepts out this cycle.
- out  output  4  one-hot decoded value: bit k set for code k.
- cnt_clr  input  1  synchronous clear of all hit counters.
- hit_cnt  output  4*CNT_W  packed counters, line k at [k*CNT_W +: CNT_W].

Behaviour:
- Reset, sampled on the rising edge while rst=1:
  - buffer count = 0, out_valid = 0, out = 4'b0000, all hit_cnt = 0.
  - in_ready = 0 while rst is high.
- Accept: in_valid && in_ready at a rising edge.
  - Entry written = en ? (4'b0001 << in_code) : 4'b0000.
- Pop: out_valid && out_ready at a rising edge. Removes the head entry.
- Buffer: 2-entry FIFO, count 0..2.
  - in_ready = (count < 2) && !rst. Combinational from registered state only, with no path from out_ready.
  - out_valid = (count != 0), registered state.
  - out = head entry when count != 0, else 4'b0000.
- Latency: a code accepted at edge N appears on out after edge N, with out_valid = 1, when the buffer was empty. One cycle, no bypass.
- Count transitions:
  - push only: +1.
  - pop only: -1.
  - push and pop together (only possible at count = 1): count stays 1, the new entry becomes the head.
  - count = 2: in_ready = 0; a pop that edge frees one slot for the next cycle.
  - count = 0: out_ready is ignored, no underflow.
- Ordering: strict FIFO. Entries are never dropped or duplicated.
- in_code and en are sampled only on an accepting edge. Changing them while in_ready = 0 has no effect.
- Hit counters:
  - On an accept with en = 1, hit_cnt[in_code] increments by 1.
  - Counters saturate at 2^CNT_W - 1 with no wrap.
  - No counter changes on an accept with en = 0, or when no accept occurs.
  - cnt_clr = 1 forces all counters to 0 on that edge. Clear wins over a simultaneous increment, so the result is 0 and not 1.
- Reset mid-operation: buffered entries are discarded; outputs return to reset values the cycle after the edge.
- The state machine is implicit in count: EMPTY (0), ONE (1), FULL (2). Transitions follow the count rules above.

Test Plan:
- Reset with in_valid = 1 and rst held 2 cycles -> in_ready = 0 and out_valid = 0 during reset; after release, in_ready = 1, out = 4'b0000, hit_cnt = 0.
- out_ready = 1, en = 1, codes 3, 2, 1, 0 on consecutive cycles -> out = 4'b1000, 4'b0100, 4'b0010, 4'b0001, each one cycle after accept; each hit_cnt line = 1.
- out_ready = 0, push codes 1 then 2 -> in_ready drops to 0 after the second accept and a third code is held off. Then set out_ready = 1 -> pops 4'b0010 then 4'b0100 in order; in_ready returns to 1 the cycle after the first pop.
- count = 1, push code 0 and pop on the same edge -> count stays 1 and out = 4'b0001 next cycle.
- en = 0 with code 2 -> out = 4'b0000 with out_valid = 1, and hit_cnt line 2 is unchanged.
- CNT_W = 2, accept code 1 five times -> hit_cnt line 1 = 3 (saturated). Then cnt_clr together with a code-1 accept -> line 1 = 0.

Source files
------------

// File: rtl/decoder2to4_stream.sv
// -----------------------------------------------------------------------------
// decoder2to4_stream
//
// Registered 2-to-4 decoder with valid/ready handshakes on both sides.
// Each accepted 2-bit code is decoded to a one-hot nibble. When en = 0 the
// nibble is 4'b0000. The nibble is stored in a 2-entry FIFO, which decouples
// upstream acceptance from downstream backpressure. One saturating hit counter
// per output line counts the accepted codes that had en = 1.
//
// Parameters
//   CNT_W      width of each per-line hit counter (1..16)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   upstream presents in_code / en
//   in_ready   a code can be accepted this cycle (registered state and rst only)
//   in_code    code to decode, 0..3
//   en         sampled with each accepted code; 0 decodes to 4'b0000
//   out_valid  out holds a valid decoded entry
//   out_ready  downstream accepts out this cycle
//   out        head entry of the buffer, 4'b0000 when the buffer is empty
//   cnt_clr    synchronous clear of all hit counters (wins over an increment)
//   hit_cnt    packed counters, line k at [k*CNT_W +: CNT_W]
// -----------------------------------------------------------------------------
module decoder2to4_stream #(
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_code,
    input  logic                 en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           out,
    input  logic                 cnt_clr,
    output logic [4*CNT_W-1:0]   hit_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Buffer state: count_q is the implicit state (0 = EMPTY, 1 = ONE, 2 = FULL).
    // head_q is the entry on out. tail_q is the second entry. A slot that holds
    // no entry is kept at 4'b0000, so out can be driven straight from head_q.
    logic [1:0]       count_q, count_d;
    logic [3:0]       head_q, head_d;
    logic [3:0]       tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    logic             push_s;
    logic             pop_s;
    logic [3:0]       entry_s;

    // One-hot decode of a code, or all-zero when disabled
    function automatic logic [3:0] decode_onehot(input logic [1:0] code, input logic enable);
        logic [3:0] result;
        result = 4'b0000;
        if (enable) begin
            case (code)
                2'd0:    result = 4'b0001;
                2'd1:    result = 4'b0010;
                2'd2:    result = 4'b0100;
                2'd3:    result = 4'b1000;
                default: result = 4'b0000;
            endcase
        end else begin
            result = 4'b0000;
        end
        return result;
    endfunction

    assign in_ready  = (count_q < 2'd2) && !rst;
    assign out_valid = (count_q != 2'd0);
    assign out       = head_q;

    for (genvar g = 0; g < 4; g++) begin : g_pack
        assign hit_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end

    // Next-state logic for the FIFO slots, the occupancy and the hit counters
    always_comb begin
        push_s  = in_valid && in_ready;
        pop_s   = out_valid && out_ready;
        entry_s = decode_onehot(in_code, en);
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;

        case ({push_s, pop_s})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = entry_s;
                end else begin
                    tail_d = entry_s;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                // tail_q is already 4'b0000 when only one entry is held, so the
                // head is cleared when the buffer becomes empty
                head_d  = tail_q;
                tail_d  = 4'b0000;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Only reachable with one entry held: the new entry replaces the head
                head_d  = entry_s;
                count_d = count_q;
            end
            default: begin
                count_d = count_q;
            end
        endcase

        for (int k = 0; k < 4; k++) begin
            cnt_d[k] = cnt_q[k];
            if (cnt_clr) begin
                cnt_d[k] = '0;
            end else if (push_s && en && (in_code == k[1:0]) && (cnt_q[k] != CNT_MAX)) begin
                cnt_d[k] = cnt_q[k] + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_d[k] = cnt_q[k];
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            head_q  <= 4'b0000;
            tail_q  <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

endmodule
